// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : edge_event_arbiter
//  Description : Per-channel edge detector with a configurable edge mode on
//                each channel. Every channel has a one-deep pending slot.
//                A round-robin arbiter drains the pending slots into a single
//                valid/ready record stage. Overruns are counted in a
//                saturating drop counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_event_arbiter #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCH-1:0]           data,
  input  logic                     cfg_we,
  input  logic [$clog2(NCH)-1:0]   cfg_ch,
  input  logic [1:0]               cfg_mode,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(NCH)-1:0]   evt_ch,
  output logic                     evt_rise,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int              CH_W   = $clog2(NCH);
  localparam logic [CH_W:0]   c_NCH  = (CH_W+1)'(NCH);
  localparam logic [CH_W-1:0] c_LAST = CH_W'(NCH-1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [NCH-1:0]        r_q;
  logic [NCH-1:0][1:0]   r_mode;
  logic [NCH-1:0]        r_pend, w_pend_nxt;
  logic [NCH-1:0]        r_type, w_type_nxt;
  logic [NCH-1:0]        w_rise, w_fall, w_edge, w_drop, w_cfg_clr, w_gnt_vec;
  logic [CH_W-1:0]       r_ptr, w_ptr_nxt;
  logic [CH_W-1:0]       r_ch, w_ch_nxt;
  logic                  r_rise, w_rise_nxt;
  logic [CH_W-1:0]       w_gnt_idx;
  logic [CH_W:0]         w_rr_sum;
  logic                  w_found, w_load, w_cfg_hit;
  logic [4:0]            w_drop_num;
  logic [CNT_W+4:0]      w_drop_sum;
  logic [CNT_W-1:0]      r_drop, w_drop_nxt;

  // Round-robin search over the registered pending flags starting at r_ptr
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_rr_sum  = '0;
    for (int k = 0; k < NCH; k++) begin
      w_rr_sum = {1'b0, r_ptr} + (CH_W+1)'(k);
      if (w_rr_sum >= c_NCH) w_rr_sum = w_rr_sum - c_NCH;
      if (!w_found && r_pend[w_rr_sum[CH_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_rr_sum[CH_W-1:0];
      end
    end
  end

  // Output-stage next state: load a new record when empty or when accepted
  always_comb begin
    w_load      = (r_state == S_IDLE) || evt_ready;
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_rise_nxt  = r_rise;
    w_ptr_nxt   = r_ptr;
    w_gnt_vec   = '0;
    if (w_load) begin
      if (w_found) begin
        w_state_nxt            = S_HOLD;
        w_ch_nxt               = w_gnt_idx;
        w_rise_nxt             = r_type[w_gnt_idx];
        w_ptr_nxt              = (w_gnt_idx == c_LAST) ? '0 : w_gnt_idx + 1'b1;
        w_gnt_vec[w_gnt_idx]   = 1'b1;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  // Edge qualification, pending-slot update, overrun detection and drop count
  always_comb begin
    w_cfg_hit  = cfg_we && ({1'b0, cfg_ch} < c_NCH);
    w_rise     = data & ~r_q;
    w_fall     = ~data & r_q;
    w_pend_nxt = r_pend;
    w_type_nxt = r_type;
    w_edge     = '0;
    w_drop     = '0;
    w_cfg_clr  = '0;
    w_drop_num = '0;
    for (int i = 0; i < NCH; i++) begin
      // Edges sampled this cycle still see the mode before any write lands
      w_edge[i]    = (r_mode[i][0] & w_rise[i]) | (r_mode[i][1] & w_fall[i]);
      w_cfg_clr[i] = w_cfg_hit && (cfg_mode == 2'b00) && (cfg_ch == CH_W'(i));
      if (w_edge[i]) begin
        if (r_pend[i] && !w_gnt_vec[i]) begin
          // Slot occupied and not draining: lose the new edge, keep old type
          w_drop[i] = 1'b1;
        end else begin
          w_pend_nxt[i] = 1'b1;
          w_type_nxt[i] = w_rise[i];
        end
      end else if (w_gnt_vec[i]) begin
        w_pend_nxt[i] = 1'b0;
      end
      if (w_cfg_clr[i]) w_pend_nxt[i] = 1'b0;
      w_drop_num = w_drop_num + 5'(w_drop[i]);
    end
    w_drop_sum = {5'b0, r_drop} + (CNT_W+5)'(w_drop_num);
    w_drop_nxt = (|w_drop_sum[CNT_W+4:CNT_W]) ? '1 : w_drop_sum[CNT_W-1:0];
  end

  // Channel history, modes, pending slots and drop counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= '0;
      r_mode <= {NCH{2'b01}};
      r_pend <= '0;
      r_type <= '0;
      r_drop <= '0;
    end else begin
      r_q    <= data;
      r_pend <= w_pend_nxt;
      r_type <= w_type_nxt;
      r_drop <= w_drop_nxt;
      if (w_cfg_hit) r_mode[cfg_ch] <= cfg_mode;
    end
  end

  // Output-stage state register, held record and arbitration pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_rise  <= 1'b0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_rise  <= w_rise_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign evt_valid = (r_state == S_HOLD);
  assign evt_ch    = r_ch;
  assign evt_rise  = r_rise;
  assign drop_cnt  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_edge_event_arbiter
//  Description : Directed self-checking bench for edge_event_arbiter. A second
//                instance with a 2-bit drop counter shares the stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] data;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic       evt_ready;
  logic       evt_valid, evt_rise;
  logic [1:0] evt_ch;
  logic [7:0] drop_cnt;
  logic       evt_valid2, evt_rise2;
  logic [1:0] evt_ch2;
  logic [1:0] drop_cnt2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  edge_event_arbiter #(.NCH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .data(data), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_ch(evt_ch), .evt_rise(evt_rise), .drop_cnt(drop_cnt)
  );

  edge_event_arbiter #(.NCH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .data(data), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .evt_valid(evt_valid2), .evt_ready(evt_ready),
    .evt_ch(evt_ch2), .evt_rise(evt_rise2), .drop_cnt(drop_cnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input logic v, input logic [1:0] ch, input logic r);
    chk({tag, "_valid"}, {31'b0, evt_valid}, {31'b0, v});
    if (v) begin
      chk({tag, "_ch"},   {30'b0, evt_ch},   {30'b0, ch});
      chk({tag, "_rise"}, {31'b0, evt_rise}, {31'b0, r});
    end
  endtask

  initial begin
    reset = 1'b1; data = 4'b0000; cfg_we = 1'b0; cfg_ch = 2'd0;
    cfg_mode = 2'b01; evt_ready = 1'b1;
    step(); step();
    // Reset state
    chk("rst_valid", {31'b0, evt_valid}, 32'd0);
    chk("rst_ch",    {30'b0, evt_ch},    32'd0);
    chk("rst_rise",  {31'b0, evt_rise},  32'd0);
    chk("rst_drop",  {24'b0, drop_cnt},  32'd0);
    chk("rst_valid2", {29'b0, evt_valid2, evt_ch2}, 32'd0);
    chk("rst_rise2",  {29'b0, evt_rise2, drop_cnt2}, 32'd0);
    reset = 1'b0;

    // Single rise on ch2 with one-cycle latency, valid for one cycle
    data = 4'b0100;
    step(); chk_rec("s1_capture", 1'b0, 2'd0, 1'b0);
    step(); chk_rec("s1_rec", 1'b1, 2'd2, 1'b1);
    step(); chk_rec("s1_done", 1'b0, 2'd0, 1'b0);

    // Fall-only mode on ch1: pulse produces only a falling record
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_mode = 2'b10;
    step(); cfg_we = 1'b0;
    data = 4'b0110;
    step(); chk_rec("s2_rise_ign", 1'b0, 2'd0, 1'b0);
    data = 4'b0100;
    step(); chk_rec("s2_fall_cap", 1'b0, 2'd0, 1'b0);
    step(); chk_rec("s2_rec", 1'b1, 2'd1, 1'b0);
    step(); chk_rec("s2_done", 1'b0, 2'd0, 1'b0);

    // Fresh start: pointer back to 0, modes back to rise
    data = 4'b0000; reset = 1'b1;
    step(); step(); reset = 1'b0;

    // Four simultaneous rises while stalled, then back-to-back drain
    evt_ready = 1'b0; data = 4'b1111;
    step(); chk_rec("s3_capture", 1'b0, 2'd0, 1'b0);
    step(); chk_rec("s3_ch0", 1'b1, 2'd0, 1'b1);
    step(); chk_rec("s3_stall_a", 1'b1, 2'd0, 1'b1);
    step(); chk_rec("s3_stall_b", 1'b1, 2'd0, 1'b1);
    evt_ready = 1'b1;
    step(); chk_rec("s3_ch1", 1'b1, 2'd1, 1'b1);
    step(); chk_rec("s3_ch2", 1'b1, 2'd2, 1'b1);
    step(); chk_rec("s3_ch3", 1'b1, 2'd3, 1'b1);
    step(); chk_rec("s3_done", 1'b0, 2'd0, 1'b0);

    // Overrun on ch0 (both-edge mode) while its record is held
    data = 4'b0000; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_mode = 2'b11;
    step(); cfg_we = 1'b0;
    data = 4'b0001;
    step(); step(); chk_rec("s4_pre", 1'b1, 2'd0, 1'b1);
    step();
    evt_ready = 1'b0; data = 4'b0000;
    step(); step(); chk_rec("s4_held", 1'b1, 2'd0, 1'b0);
    data = 4'b0001; step();
    data = 4'b0000; step();
    data = 4'b0001; step();
    chk("s4_drop2", {24'b0, drop_cnt}, 32'd2);
    chk_rec("s4_unchanged", 1'b1, 2'd0, 1'b0);
    evt_ready = 1'b1;
    step(); chk_rec("s4_pending", 1'b1, 2'd0, 1'b1);
    step(); chk_rec("s4_done", 1'b0, 2'd0, 1'b0);

    // Saturation of the 2-bit counter and two drops in one cycle
    evt_ready = 1'b0; data = 4'b0000;
    step(); step();
    data = 4'b0001; step();
    data = 4'b0000; step();
    chk("s5_sat_d3", {30'b0, drop_cnt2}, 32'd3);
    data = 4'b0001; step();
    chk("s5_sat_d4", {30'b0, drop_cnt2}, 32'd3);
    chk("s5_cnt_d4", {24'b0, drop_cnt}, 32'd4);
    data = 4'b0000; step();
    chk("s5_cnt_d5", {24'b0, drop_cnt}, 32'd5);
    chk("s5_sat_d5", {30'b0, drop_cnt2}, 32'd3);
    data = 4'b0110; step();
    data = 4'b0000; step();
    data = 4'b0110; step();
    chk("s5_multi", {24'b0, drop_cnt}, 32'd7);
    chk("s5_multi_sat", {30'b0, drop_cnt2}, 32'd3);
    chk_rec("s5_held", 1'b1, 2'd0, 1'b0);

    // Asynchronous reset mid-transfer with pending events
    #3 reset = 1'b1;
    #1;
    chk("s6_async_valid", {31'b0, evt_valid}, 32'd0);
    chk("s6_async_drop",  {24'b0, drop_cnt},  32'd0);
    data = 4'b0000;
    step(); step(); reset = 1'b0; evt_ready = 1'b1;
    step(); chk_rec("s6_stale_a", 1'b0, 2'd0, 1'b0);
    step(); chk_rec("s6_stale_b", 1'b0, 2'd0, 1'b0);
    step(); chk_rec("s6_stale_c", 1'b0, 2'd0, 1'b0);

    // Channel high at reset release registers a rise; mode 00 clears pending
    reset = 1'b1; data = 4'b1000;
    step(); reset = 1'b0; evt_ready = 1'b0;
    step(); chk_rec("s7_capture", 1'b0, 2'd0, 1'b0);
    step(); chk_rec("s7_rec", 1'b1, 2'd3, 1'b1);
    data = 4'b1100;
    step();
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_mode = 2'b00;
    step(); chk_rec("s7_cfg_keep", 1'b1, 2'd3, 1'b1);
    cfg_we = 1'b0; evt_ready = 1'b1;
    step(); chk_rec("s7_cleared", 1'b0, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
